// File: rtl/lzw_pkg.sv
// Shared constants and types for the LZW dictionary store.
package lzw_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 4096;
    localparam int FIRST_CODE = 256;

    typedef logic [11:0] code_t;
    typedef logic [63:0] word_t;

endpackage

// File: rtl/single_port_sync_ram_if.sv
// Request/response bundle between the LZW lookup logic (master) and the dictionary RAM (slave).
interface single_port_sync_ram_if
    import lzw_pkg::*;
#(
    parameter int AW = lzw_pkg::ADDR_WIDTH,
    parameter int DW = lzw_pkg::DATA_WIDTH
);

    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          cs;
    logic          we;
    logic [DW-1:0] data_out;
    logic [AW-1:0] map_out;
    logic          valid;

    modport master (
        output addr, data_in, cs, we,
        input  data_out, map_out, valid
    );

    modport slave (
        input  addr, data_in, cs, we,
        output data_out, map_out, valid
    );

endinterface

// File: rtl/spram_core.sv
// Array-only data + code RAM with a registered, write-first read port, shaped for BRAM inference.
module spram_core
    import lzw_pkg::*;
#(
    parameter int ADDR_WIDTH = lzw_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = lzw_pkg::DATA_WIDTH,
    parameter int DEPTH      = lzw_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_dataWe,
    input  logic                  i_codeWe,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_code,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_code
);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [ADDR_WIDTH-1:0] r_code [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdData;
    logic [ADDR_WIDTH-1:0] r_rdCode;

    // Code and data have separate write enables: rewriting an existing entry keeps its code.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_dataWe) begin
                r_data[i_addr] <= i_data;
            end
            if (i_codeWe) begin
                r_code[i_addr] <= i_code;
            end
            r_rdData <= i_dataWe ? i_data : r_data[i_addr];
            r_rdCode <= i_codeWe ? i_code : r_code[i_addr];
        end
    end

    assign o_data = r_rdData;
    assign o_code = r_rdCode;

endmodule

// File: rtl/single_port_sync_ram.sv
// LZW dictionary store: valid bits, code allocator and output control around spram_core.
// Optional macro SPRAM_WRITE_FIRST_EN: successful writes are echoed on the outputs next cycle.
module single_port_sync_ram
    import lzw_pkg::*;
#(
    parameter int ADDR_WIDTH = lzw_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = lzw_pkg::DATA_WIDTH,
    parameter int DEPTH      = lzw_pkg::DEPTH,
    parameter int FIRST_CODE = lzw_pkg::FIRST_CODE
) (
    input  logic                 clk,
    input  logic                 rst,
    single_port_sync_ram_if.slave bus
);

    logic [DEPTH-1:0]      r_validBits;
    logic [ADDR_WIDTH-1:0] r_nextCode;
    logic                  r_full;
    logic                  r_valid;
    logic                  r_showCore;
    logic                  r_coreHit;
    logic [DATA_WIDTH-1:0] r_holdData;
    logic [ADDR_WIDTH-1:0] r_holdCode;

    logic                  w_hit;
    logic                  w_writeReq;
    logic                  w_ignore;
    logic                  w_coreEn;
    logic                  w_dataWe;
    logic                  w_codeWe;
    logic [DATA_WIDTH-1:0] w_coreData;
    logic [ADDR_WIDTH-1:0] w_coreCode;
    logic [DATA_WIDTH-1:0] w_dataOut;
    logic [ADDR_WIDTH-1:0] w_mapOut;

    assign w_hit      = r_validBits[bus.addr];
    assign w_writeReq = bus.cs & bus.we;
    assign w_ignore   = w_writeReq & ~w_hit & r_full;
    assign w_coreEn   = bus.cs & ~rst;
    assign w_dataWe   = w_writeReq & ~w_ignore & ~rst;
    assign w_codeWe   = w_writeReq & ~w_hit & ~r_full & ~rst;

    spram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk      (clk),
        .i_en     (w_coreEn),
        .i_dataWe (w_dataWe),
        .i_codeWe (w_codeWe),
        .i_addr   (bus.addr),
        .i_data   (bus.data_in),
        .i_code   (r_nextCode),
        .o_data   (w_coreData),
        .o_code   (w_coreCode)
    );

    // Outputs either show the core's read port (zeroed on a miss) or replay the last presented value.
    assign w_dataOut = r_showCore ? (r_coreHit ? w_coreData : '0) : r_holdData;
    assign w_mapOut  = r_showCore ? (r_coreHit ? w_coreCode : '0) : r_holdCode;

    assign bus.data_out = w_dataOut;
    assign bus.map_out  = w_mapOut;
    assign bus.valid    = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_validBits <= '0;
            r_nextCode  <= ADDR_WIDTH'(FIRST_CODE);
            r_full      <= 1'b0;
            r_valid     <= 1'b0;
            r_showCore  <= 1'b0;
            r_coreHit   <= 1'b0;
            r_holdData  <= '0;
            r_holdCode  <= '0;
        end else begin
            r_holdData <= w_dataOut;
            r_holdCode <= w_mapOut;
            r_valid    <= 1'b0;
            r_showCore <= 1'b0;
            r_coreHit  <= 1'b0;
            if (bus.cs && !bus.we) begin
                r_showCore <= 1'b1;
                r_coreHit  <= w_hit;
                r_valid    <= w_hit;
            end else if (w_writeReq && !w_ignore) begin
                // Counter parks at the last code instead of wrapping; full latches until reset.
                if (w_codeWe) begin
                    r_validBits[bus.addr] <= 1'b1;
                    if (r_nextCode == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_full <= 1'b1;
                    end else begin
                        r_nextCode <= r_nextCode + 1'b1;
                    end
                end
`ifdef SPRAM_WRITE_FIRST_EN
                r_showCore <= 1'b1;
                r_coreHit  <= 1'b1;
                r_valid    <= 1'b1;
`else
                r_showCore <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Scoreboard bench for single_port_sync_ram: directed vectors queue expectations, a monitor checks them.
module tb_single_port_sync_ram;
    import lzw_pkg::*;

`ifdef SPRAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    typedef struct {
        int          due;
        string       name;
        logic        expValid;
        logic [63:0] expData;
        logic [11:0] expMap;
        bit          chk;
    } exp_t;

    logic clk;
    logic rst;
    int   cycleCount;
    int   assertCount;
    int   failCount;
    exp_t sbQueue[$];
    exp_t monItem;

    single_port_sync_ram_if bus ();

    single_port_sync_ram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount = cycleCount + 1;

    // Issue one operation on the next edge and queue what the outputs must show after it.
    task automatic applyStimulus(input string name, input logic r, input logic c, input logic w,
                                 input logic [11:0] a, input logic [63:0] d, input logic ev,
                                 input logic [63:0] ed, input logic [11:0] em, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        bus.cs      = c;
        bus.we      = w;
        bus.addr    = a;
        bus.data_in = d;
        e.due      = cycleCount + 1;
        e.name     = name;
        e.expValid = ev;
        e.expData  = ed;
        e.expMap   = em;
        e.chk      = chk;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        assertCount = assertCount + 1;
        if (bus.valid !== e.expValid ||
            (e.chk && (bus.data_out !== e.expData || bus.map_out !== e.expMap))) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got valid=%0b data=%h map=%0d, expected valid=%0b data=%h map=%0d%s",
                     e.name, bus.valid, bus.data_out, bus.map_out, e.expValid, e.expData, e.expMap,
                     e.chk ? "" : " (valid only)");
        end
    endtask

    task automatic doWrite(input string name, input logic [11:0] a, input logic [63:0] d,
                           input logic [11:0] code);
        applyStimulus(name, 1'b0, 1'b1, 1'b1, a, d, WF, d, code, WF);
    endtask

    task automatic doRead(input string name, input logic [11:0] a, input logic ev,
                          input logic [63:0] ed, input logic [11:0] em);
        applyStimulus(name, 1'b0, 1'b1, 1'b0, a, 64'h0, ev, ed, em, 1'b1);
    endtask

    // Monitor: pops every expectation due at this cycle and compares it against the outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (sbQueue.size() > 0 && sbQueue[0].due <= cycleCount) begin
                monItem = sbQueue.pop_front();
                if (monItem.due < cycleCount) begin
                    assertCount = assertCount + 1;
                    failCount   = failCount + 1;
                    $display("[TB] FAIL %s: expectation stale, due cycle %0d, now %0d",
                             monItem.name, monItem.due, cycleCount);
                end else begin
                    checkOutput(monItem);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        failCount = failCount + 1;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d checks pending", sbQueue.size());
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        int          filled;
        logic [11:0] lastFill;
        logic [11:0] fa;
        cycleCount  = 0;
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        bus.cs      = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;

        applyStimulus("reset", 1'b1, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0, 12'd0, 1'b1);
        doRead("read_empty_257", 12'h257, 1'b0, 64'h0, 12'd0);

        doWrite("wr_483", 12'h483, 64'h4241, 12'd256);
        doWrite("wr_485", 12'h485, 64'h434241, 12'd257);
        doWrite("wr_285", 12'h285, 64'h4142, 12'd258);
        doRead("rd_483", 12'h483, 1'b1, 64'h4241, 12'd256);
        doRead("rd_485", 12'h485, 1'b1, 64'h434241, 12'd257);
        doRead("rd_285", 12'h285, 1'b1, 64'h4142, 12'd258);

        doWrite("rewr_483", 12'h483, 64'h5A5A, 12'd256);
        doRead("rd_483_rewritten", 12'h483, 1'b1, 64'h5A5A, 12'd256);
        applyStimulus("idle_hold", 1'b0, 1'b0, 1'b0, 12'h483, 64'h0, 1'b0, 64'h5A5A, 12'd256, 1'b1);

        doWrite("wr_100_code259", 12'h100, 64'h77, 12'd259);
        doRead("rd_100_after_wr", 12'h100, 1'b1, 64'h77, 12'd259);

        applyStimulus("cs_low_we_1", 1'b0, 1'b0, 1'b1, 12'h010, 64'hDEAD, 1'b0, 64'h77, 12'd259, 1'b1);
        applyStimulus("cs_low_we_2", 1'b0, 1'b0, 1'b1, 12'h010, 64'hDEAD, 1'b0, 64'h77, 12'd259, 1'b1);
        doRead("rd_010_unwritten", 12'h010, 1'b0, 64'h0, 12'd0);

        // Codes 256..259 are taken; 3836 more fresh entries take the allocator to 4095.
        filled   = 0;
        lastFill = '0;
        for (int a = 0; a < 4096 && filled < 3836; a++) begin
            fa = a[11:0];
            if (fa == 12'h483 || fa == 12'h485 || fa == 12'h285 || fa == 12'h100 ||
                fa == 12'h010 || fa == 12'hFFF) continue;
            doWrite("fill", fa, {52'h0, fa}, 12'(260 + filled));
            lastFill = fa;
            filled++;
        end
        doRead("rd_last_code_4095", lastFill, 1'b1, {52'h0, lastFill}, 12'd4095);

        applyStimulus("wr_when_full", 1'b0, 1'b1, 1'b1, 12'hFFF, 64'h99, 1'b0, 64'h0, 12'd0, 1'b0);
        doRead("rd_fff_ignored", 12'hFFF, 1'b0, 64'h0, 12'd0);
        doWrite("rewr_483_full", 12'h483, 64'h1234, 12'd256);
        doRead("rd_483_full", 12'h483, 1'b1, 64'h1234, 12'd256);

        applyStimulus("reset_with_write", 1'b1, 1'b1, 1'b1, 12'h050, 64'h55, 1'b0, 64'h0, 12'd0, 1'b1);
        doRead("rd_483_after_rst", 12'h483, 1'b0, 64'h0, 12'd0);
        doRead("rd_050_discarded", 12'h050, 1'b0, 64'h0, 12'd0);
        doWrite("wr_600_after_rst", 12'h600, 64'hABCD, 12'd256);
        doRead("rd_600_code256", 12'h600, 1'b1, 64'hABCD, 12'd256);
        applyStimulus("final_idle", 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 64'hABCD, 12'd256, 1'b1);

        for (int i = 0; i < 5 && sbQueue.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sbQueue.size() != 0) begin
            failCount = failCount + 1;
            $display("[TB] FAIL drain: %0d expectations never checked, expected 0", sbQueue.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
